// File: rtl/dbg_inst_encoder_pkg.sv
// Shared constants and types for the debug instruction encoder.
// RV32I opcodes/funct3 values, debug command codes, the DSCRATCH CSR
// address, the FSM state type and the encoder instruction-kind selector.
package dbg_inst_encoder_pkg;

  // RV32I major opcodes
  localparam logic [6:0] INST_LUI    = 7'b0110111;
  localparam logic [6:0] INST_TYPE_I = 7'b0010011;
  localparam logic [6:0] INST_TYPE_L = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S = 7'b0100011;
  localparam logic [6:0] INST_CSR    = 7'b1110011;

  // funct3 values
  localparam logic [2:0] F3_ADDI  = 3'b000;
  localparam logic [2:0] F3_LW    = 3'b010;
  localparam logic [2:0] F3_SW    = 3'b010;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;

  // Debug command op codes
  localparam logic [1:0] DBG_CMD_REG_RD = 2'd0;
  localparam logic [1:0] DBG_CMD_REG_WR = 2'd1;
  localparam logic [1:0] DBG_CMD_MEM_RD = 2'd2;
  localparam logic [1:0] DBG_CMD_MEM_WR = 2'd3;

  // Debug scratch CSR
  localparam logic [11:0] DSCRATCH_CSR_ADDR = 12'h7B2;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_LOAD_HI = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_RESTORE = 3'd4,
    ST_DONE    = 3'd5
  } dbg_state_e;

  // Which instruction the encoder should build
  typedef enum logic [2:0] {
    K_NONE  = 3'd0,
    K_LUI   = 3'd1,
    K_ADDI  = 3'd2,
    K_LW    = 3'd3,
    K_SW    = 3'd4,
    K_CSRRW = 3'd5,
    K_CSRRS = 3'd6
  } enc_kind_e;

  // Registered debug command
  typedef struct packed {
    logic [1:0]  op;
    logic [4:0]  regno;
    logic [31:0] addr;
    logic [31:0] data;
  } dbg_cmd_t;

endpackage

// File: rtl/dbg_inst_encoder_rv_enc.sv
// Combinational RV32I encoder: hi/lo split of a 32-bit value plus the
// U (LUI), I (ADDI/LW), S (SW) and CSR (CSRRW/CSRRS) formats.
// hi = (v + 0x800) >> 12 so that (hi << 12) + sext(v[11:0]) == v.
module dbg_rv_enc
  import dbg_inst_encoder_pkg::*;
#(
  parameter logic [11:0] CSR_ADDR = DSCRATCH_CSR_ADDR
) (
  input  enc_kind_e   kind_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] val_i,
  output logic [31:0] inst_o
);

  logic [31:0] hi_sum;
  logic [11:0] lo;

  // Build the selected instruction word; K_NONE yields all zeros.
  always_comb begin
    hi_sum = val_i + 32'h0000_0800;
    lo     = val_i[11:0];
    inst_o = 32'h0;
    case (kind_i)
      K_LUI:   inst_o = {hi_sum[31:12], rd_i, INST_LUI};
      K_ADDI:  inst_o = {lo, rs1_i, F3_ADDI, rd_i, INST_TYPE_I};
      K_LW:    inst_o = {lo, rs1_i, F3_LW, rd_i, INST_TYPE_L};
      K_SW:    inst_o = {lo[11:5], rs2_i, rs1_i, F3_SW, lo[4:0], INST_TYPE_S};
      K_CSRRW: inst_o = {CSR_ADDR, rs1_i, F3_CSRRW, rd_i, INST_CSR};
      K_CSRRS: inst_o = {CSR_ADDR, rs1_i, F3_CSRRS, rd_i, INST_CSR};
      default: inst_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dbg_inst_encoder.sv
// Debug instruction generator: turns REG_RD/REG_WR/MEM_RD/MEM_WR commands
// into short RV32I sequences fed one at a time to the fetch path.
// Optional feature macro: DBG_SCRATCH_SAVE_EN wraps MEM_* with a SAVE/RESTORE
// of the scratch GPR through DSCRATCH so that register is preserved.
//
// Handshakes: cmd is taken on cmd_valid_i & cmd_ready_o; an instruction is
// taken on inst_valid_o & inst_ready_i. While valid is high and ready is low
// the producer holds its payload stable. abort_i outside IDLE ends the
// sequence (a same-cycle instruction accept still counts as issued).
module dbg_inst_encoder
  import dbg_inst_encoder_pkg::*;
#(
  parameter logic [4:0]  SCRATCH_REG  = 5'd31,
  parameter logic [11:0] DSCRATCH_CSR = DSCRATCH_CSR_ADDR,
  parameter logic [31:0] INST_ADDR    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [4:0]  cmd_regno_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  input  logic        abort_i,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o
);

`ifdef DBG_SCRATCH_SAVE_EN
  localparam bit SAVE_EN = 1'b1;
`else
  localparam bit SAVE_EN = 1'b0;
`endif

  dbg_state_e  state_q, state_d;
  dbg_cmd_t    cmd_q, cmd_d, cur_cmd;
  logic        err_q, err_d;
  logic [31:0] inst_q, inst_d;

  logic        emit;
  logic        inst_acc;
  logic        cur_is_mem;

  enc_kind_e   enc_kind;
  logic [4:0]  enc_rd, enc_rs1, enc_rs2;
  logic [31:0] enc_val;

  // In IDLE the incoming command drives encoding, otherwise the registered one.
  always_comb begin
    cur_cmd    = (state_q == ST_IDLE) ? {cmd_op_i, cmd_regno_i, cmd_addr_i, cmd_data_i}
                                      : cmd_q;
    cur_is_mem = cur_cmd.op[1];
    emit       = (state_q == ST_SAVE) || (state_q == ST_LOAD_HI) ||
                 (state_q == ST_ACCESS) || (state_q == ST_RESTORE);
    inst_acc   = emit && inst_ready_i;
  end

  // Next-state logic: command capture, sequencing, abort handling.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_d = cur_cmd;
          err_d = 1'b0;
          if (cur_is_mem && (cur_cmd.regno == SCRATCH_REG)) begin
            // Data register would be clobbered by the base: reject.
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (cur_cmd.op == DBG_CMD_REG_RD) begin
            state_d = ST_ACCESS;
          end else if (cur_cmd.op == DBG_CMD_REG_WR) begin
            state_d = ST_LOAD_HI;
          end else begin
            state_d = SAVE_EN ? ST_SAVE : ST_LOAD_HI;
          end
        end
      end
      ST_SAVE, ST_LOAD_HI, ST_ACCESS, ST_RESTORE: begin
        if (abort_i) begin
          err_d = 1'b1;
          if (SAVE_EN && cur_is_mem) begin
            // Once SAVE has been issued, RESTORE must still go out.
            if ((state_q == ST_SAVE) && !inst_acc)
              state_d = ST_DONE;
            else if ((state_q == ST_RESTORE) && inst_acc)
              state_d = ST_DONE;
            else
              state_d = ST_RESTORE;
          end else begin
            state_d = ST_DONE;
          end
        end else if (inst_acc) begin
          case (state_q)
            ST_SAVE:    state_d = ST_LOAD_HI;
            ST_LOAD_HI: state_d = ST_ACCESS;
            ST_ACCESS:  state_d = (SAVE_EN && cur_is_mem) ? ST_RESTORE : ST_DONE;
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand selection for the instruction the next state will present.
  always_comb begin
    enc_kind = K_NONE;
    enc_rd   = 5'd0;
    enc_rs1  = 5'd0;
    enc_rs2  = 5'd0;
    enc_val  = 32'h0;
    case (state_d)
      ST_SAVE: begin
        enc_kind = K_CSRRW;
        enc_rs1  = SCRATCH_REG;
      end
      ST_LOAD_HI: begin
        enc_kind = K_LUI;
        if (cur_cmd.op == DBG_CMD_REG_WR) begin
          enc_rd  = cur_cmd.regno;
          enc_val = cur_cmd.data;
        end else begin
          enc_rd  = SCRATCH_REG;
          enc_val = cur_cmd.addr;
        end
      end
      ST_ACCESS: begin
        case (cur_cmd.op)
          DBG_CMD_REG_RD: begin
            enc_kind = K_CSRRW;
            enc_rs1  = cur_cmd.regno;
          end
          DBG_CMD_REG_WR: begin
            enc_kind = K_ADDI;
            enc_rd   = cur_cmd.regno;
            enc_rs1  = cur_cmd.regno;
            enc_val  = cur_cmd.data;
          end
          DBG_CMD_MEM_RD: begin
            enc_kind = K_LW;
            enc_rd   = cur_cmd.regno;
            enc_rs1  = SCRATCH_REG;
            enc_val  = cur_cmd.addr;
          end
          default: begin
            enc_kind = K_SW;
            enc_rs1  = SCRATCH_REG;
            enc_rs2  = cur_cmd.regno;
            enc_val  = cur_cmd.addr;
          end
        endcase
      end
      ST_RESTORE: begin
        enc_kind = K_CSRRS;
        enc_rd   = SCRATCH_REG;
      end
      default: enc_kind = K_NONE;
    endcase
  end

  dbg_rv_enc #(
    .CSR_ADDR (DSCRATCH_CSR)
  ) u_enc (
    .kind_i (enc_kind),
    .rd_i   (enc_rd),
    .rs1_i  (enc_rs1),
    .rs2_i  (enc_rs2),
    .val_i  (enc_val),
    .inst_o (inst_d)
  );

  // State, command, error flag and instruction registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      err_q   <= 1'b0;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      inst_q  <= inst_d;
    end
  end

  assign cmd_ready_o  = (state_q == ST_IDLE);
  assign inst_valid_o = emit;
  assign inst_o       = inst_q;
  assign inst_addr_o  = INST_ADDR;
  assign done_o       = (state_q == ST_DONE);
  assign err_o        = (state_q == ST_DONE) && err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dbg_inst_encoder.sv
// Self-checking bench for dbg_inst_encoder: directed cases plus randomized
// commands checked against an instruction-list reference model.
module tb_dbg_inst_encoder;

`ifdef DBG_SCRATCH_SAVE_EN
  localparam bit SAVE_EN = 1'b1;
`else
  localparam bit SAVE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;
  logic [4:0]  cmd_regno_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        abort_i;
  logic        done_o;
  logic        err_o;
  logic [2:0]  dbg_state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  dbg_inst_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_regno_i  (cmd_regno_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .abort_i      (abort_i),
    .done_o       (done_o),
    .err_o        (err_o),
    .dbg_state_o  (dbg_state_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference encodings, straight from the RV32I formats
  function automatic logic [31:0] m_lui(input logic [4:0] rd, input logic [31:0] v);
    logic [31:0] h;
    h = (v + 32'h800) >> 12;
    return {h[19:0], rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] m_addi(input logic [4:0] rd, input logic [31:0] v);
    return {v[11:0], rd, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] m_lw(input logic [4:0] rd, input logic [31:0] v);
    return {v[11:0], 5'd31, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] m_sw(input logic [4:0] rs2, input logic [31:0] v);
    return {v[11:5], rs2, 5'd31, 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] m_csr(input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [4:0] rs1);
    return {12'h7B2, rs1, f3, rd, 7'b1110011};
  endfunction

  // expected instruction list and error flag for one command
  task automatic model_build(input logic [1:0] op, input logic [4:0] regno,
                             input logic [31:0] addr, input logic [31:0] data,
                             output logic exp_err);
    exp_q.delete();
    exp_err = 1'b0;
    if (op[1] && regno == 5'd31) begin
      exp_err = 1'b1;
      return;
    end
    case (op)
      2'd0: exp_q.push_back(m_csr(3'b001, 5'd0, regno));
      2'd1: begin
        exp_q.push_back(m_lui(regno, data));
        exp_q.push_back(m_addi(regno, data));
      end
      default: begin
        if (SAVE_EN) exp_q.push_back(m_csr(3'b001, 5'd0, 5'd31));
        exp_q.push_back(m_lui(5'd31, addr));
        if (op == 2'd2) exp_q.push_back(m_lw(regno, addr));
        else            exp_q.push_back(m_sw(regno, addr));
        if (SAVE_EN) exp_q.push_back(m_csr(3'b010, 5'd31, 5'd0));
      end
    endcase
  endtask

  // driver: one command, exp_q preloaded by caller; starts one cycle after done/reset
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] regno,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_err, input int stall_pct, input int stall_at,
                         input int abort_at, input bit hold_valid);
    int vcyc, issued;
    bit stalled, done_seen, aborted, rdy, ab, pend;
    logic [31:0] prev_inst;
    logic err_exp;
    vcyc = 0; issued = 0; stalled = 0; done_seen = 0; aborted = 0;
    prev_inst = 32'h0; err_exp = exp_err;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i = 1'b1; cmd_op_i = op; cmd_regno_i = regno;
    cmd_addr_i = addr; cmd_data_i = data;
    inst_ready_i = 1'b0; abort_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (!hold_valid) cmd_valid_i = 1'b0;
      if (done_o) begin
        chk("done_err", 32'(err_o), 32'(err_exp));
        chk("done_latency", 32'(k), 32'(vcyc + 1));
        chk("insts_left", 32'(exp_q.size()), 32'd0);
        chk("valid_at_done", 32'(inst_valid_o), 32'd0);
        inst_ready_i = 1'b0; abort_i = 1'b0;
        done_seen = 1;
        break;
      end
      chk("busy_ready", 32'(cmd_ready_o), 32'd0);
      if (stalled) begin
        chk("hold_inst", inst_o, prev_inst);
        chk("hold_valid", 32'(inst_valid_o), 32'd1);
      end
      if (inst_valid_o) begin
        rdy = ($urandom_range(99) >= stall_pct);
        if (stall_at >= 0 && vcyc >= stall_at && vcyc < stall_at + 6) rdy = 1'b0;
        ab = (vcyc == abort_at) && !aborted;
        inst_ready_i = rdy; abort_i = ab;
        if (rdy) begin
          if (exp_q.size() == 0) chk("extra_inst", 32'(inst_valid_o), 32'd0);
          else begin
            chk("inst", inst_o, exp_q.pop_front());
            chk("inst_addr", inst_addr_o, 32'h0);
            issued++;
          end
        end
        if (ab) begin
          aborted = 1; err_exp = 1'b1;
          pend = SAVE_EN && op[1] && issued >= 1 && exp_q.size() > 0;
          exp_q.delete();
          if (pend) exp_q.push_back(m_csr(3'b010, 5'd31, 5'd0));
        end
        stalled = !rdy && !ab;
        prev_inst = inst_o;
        vcyc++;
      end else begin
        chk("stuck_no_done", 32'(done_o), 32'd1);
        inst_ready_i = 1'b0; abort_i = 1'b0; stalled = 0;
      end
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    cmd_valid_i = hold_valid;
    inst_ready_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic run_model(input logic [1:0] op, input logic [4:0] regno,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int stall_pct, input int stall_at, input int abort_at,
                           input bit hold_valid);
    logic e;
    model_build(op, regno, addr, data, e);
    run_cmd(op, regno, addr, data, e, stall_pct, stall_at, abort_at, hold_valid);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(cmd_ready_o), 32'd1);
    chk({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
    chk({tag, "_inst"},  inst_o, 32'h0);
    chk({tag, "_done"},  32'(done_o), 32'd0);
    chk({tag, "_err"},   32'(err_o), 32'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [4:0]  rg;
    logic [31:0] ad, da;
    int sp, ab;
    rst = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_regno_i = 5'd0;
    cmd_addr_i = 32'h0; cmd_data_i = 32'h0; inst_ready_i = 1'b0; abort_i = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;

    // REG_WR x5 = 0x12345FFF
    exp_q.delete();
    exp_q.push_back(32'h123462B7);
    exp_q.push_back(32'hFFF28293);
    run_cmd(2'd1, 5'd5, 32'h0, 32'h12345FFF, 1'b0, 0, -1, -1, 1'b0);

    // REG_RD x10
    exp_q.delete();
    exp_q.push_back(32'h7B251073);
    run_cmd(2'd0, 5'd10, 32'h0, 32'h0, 1'b0, 0, -1, -1, 1'b0);

    // MEM_WR x7 @0x80000804
    exp_q.delete();
    if (SAVE_EN) exp_q.push_back(32'h7B2F9073);
    exp_q.push_back(32'h80001FB7);
    exp_q.push_back(32'h807FA223);
    if (SAVE_EN) exp_q.push_back(32'h7B202FF3);
    run_cmd(2'd3, 5'd7, 32'h80000804, 32'h0, 1'b0, 0, -1, -1, 1'b0);

    // MEM_RD into the scratch register is rejected
    exp_q.delete();
    run_cmd(2'd2, 5'd31, 32'h00000100, 32'h0, 1'b1, 0, -1, -1, 1'b0);

    // stall 5 cycles then abort while stalled
    run_model(2'd2, 5'd3, 32'h00001000, 32'h0, 0, 1, 6, 1'b0);

    // REG_WR to x0 and boundary immediates
    run_model(2'd1, 5'd0, 32'h0, 32'hFFFFF800, 0, -1, -1, 1'b0);
    run_model(2'd1, 5'd9, 32'h0, 32'h000007FF, 0, -1, -1, 1'b0);
    run_model(2'd2, 5'd4, 32'hFFFFF800, 32'h0, 0, -1, -1, 1'b0);

    // back-to-back with cmd_valid_i held
    run_model(2'd1, 5'd12, 32'h0, 32'h00000800, 0, -1, -1, 1'b1);
    run_model(2'd0, 5'd1, 32'h0, 32'h0, 0, -1, -1, 1'b1);
    run_model(2'd3, 5'd2, 32'h7FFFFFFC, 32'h0, 0, -1, -1, 1'b0);

    // reset mid-sequence
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_op_i = 2'd1; cmd_regno_i = 5'd6; cmd_data_i = 32'hDEADBEEF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b1;

    // randomized commands
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom_range(3));
      rg = ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(31));
      ad = $urandom & 32'hFFFFFFFC;
      case ($urandom_range(4))
        0: da = 32'hFFFFF800;
        1: da = 32'h000007FF;
        2: da = 32'h00000800;
        default: da = $urandom;
      endcase
      sp = ($urandom_range(1) == 0) ? 0 : 40;
      ab = ($urandom_range(4) == 0) ? $urandom_range(3) : -1;
      run_model(op, rg, ad, da, sp, -1, ab, bit'($urandom_range(1)));
    end

    @(negedge clk);
    cmd_valid_i = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
